// File: rtl/flash_pkg.sv
// Shared definitions for the flash access arbiter: bus widths, op encoding,
// FSM state encoding and the latched command record.
package flash_pkg;
  localparam int FLASH_ADDR_W = 24;
  localparam int FLASH_DATA_W = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic                    op;
    logic [FLASH_ADDR_W-1:0] addr;
    logic [FLASH_DATA_W-1:0] wdata;
    logic                    id;
  } cmd_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side
// that was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       valid,
  output logic       id
);
  always_comb begin
    valid = |req;
    if (&req) id = ~last_gnt;
    else      id = req[1];
  end
endmodule

// File: rtl/flash_access_arbiter.sv
// Shares one byte-read/byte-write flash engine between two requesters with
// round-robin arbitration, trigger/done sequencing and a stall watchdog.
module flash_access_arbiter
  import flash_pkg::*;
#(
  parameter int TIMEOUT_CYC = 25_000_000
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    r0_req,
  input  logic                    r0_we,
  input  logic [FLASH_ADDR_W-1:0] r0_addr,
  input  logic [FLASH_DATA_W-1:0] r0_wdata,
  output logic                    r0_ack,
  output logic                    r0_done,
  output logic [FLASH_DATA_W-1:0] r0_rdata,
  output logic                    r0_err,
  input  logic                    r1_req,
  input  logic                    r1_we,
  input  logic [FLASH_ADDR_W-1:0] r1_addr,
  input  logic [FLASH_DATA_W-1:0] r1_wdata,
  output logic                    r1_ack,
  output logic                    r1_done,
  output logic [FLASH_DATA_W-1:0] r1_rdata,
  output logic                    r1_err,
  output logic [FLASH_ADDR_W-1:0] flash_addr,
  output logic [FLASH_DATA_W-1:0] write_byte,
  output logic                    write_trigger,
  output logic                    read_trigger,
  input  logic                    write_done,
  input  logic                    read_done,
  input  logic [FLASH_DATA_W-1:0] read_byte,
  output logic [1:0]              fsm_state
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       state;
  cmd_t             cmd;
  logic             last_gnt;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             pick_valid;
  logic             pick_id;
  logic             grant;
  logic             match;
  logic             timeout;
  logic             resp;
  logic             issue;

  rr_arb2 u_arb (
    .req      ({r1_req, r0_req}),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .id       (pick_id)
  );

  // Only the done pulse matching the latched op can end the wait.
  assign match   = (cmd.op == OP_WRITE) ? write_done : read_done;
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sclk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cmd      <= '0;
      last_gnt <= 1'b1;
      cnt      <= '0;
      err      <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            cmd.op    <= pick_id ? r1_we    : r0_we;
            cmd.addr  <= pick_id ? r1_addr  : r0_addr;
            cmd.wdata <= pick_id ? r1_wdata : r0_wdata;
            cmd.id    <= pick_id;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (match) begin
            err   <= 1'b0;
            state <= ST_RESP;
            if (cmd.op == OP_READ) begin
              if (cmd.id) r1_rdata <= read_byte;
              else        r0_rdata <= read_byte;
            end
          end else if (timeout) begin
            err   <= 1'b1;
            state <= ST_RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          last_gnt <= cmd.id;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pulses are decoded from state and suppressed while reset is held.
  assign grant = (state == ST_IDLE) && pick_valid && !rst;
  assign issue = (state == ST_ISSUE) && !rst;
  assign resp  = (state == ST_RESP) && !rst;

  assign r0_ack        = grant && !pick_id;
  assign r1_ack        = grant && pick_id;
  assign write_trigger = issue && (cmd.op == OP_WRITE);
  assign read_trigger  = issue && (cmd.op == OP_READ);
  assign r0_done       = resp && !cmd.id;
  assign r1_done       = resp && cmd.id;
  assign r0_err        = r0_done && err;
  assign r1_err        = r1_done && err;
  assign flash_addr    = cmd.addr;
  assign write_byte    = cmd.wdata;
  assign fsm_state     = state;
endmodule

// File: tb/tb_flash_access_arbiter.sv
// Bench for flash_access_arbiter: behavioural flash engine with programmable
// latency, requester-side memory model, and directed plus randomized steps.
module tb_flash_access_arbiter;
  import flash_pkg::*;

  localparam int TO = 64;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [7:0]  wb;
  } log_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [23:0] r0_addr, r1_addr;
  logic [7:0]  r0_wdata, r1_wdata;
  logic        r0_ack, r0_done, r0_err, r1_ack, r1_done, r1_err;
  logic [7:0]  r0_rdata, r1_rdata;
  logic [23:0] flash_addr;
  logic [7:0]  write_byte;
  logic        write_trigger, read_trigger;
  logic        write_done, read_done;
  logic [7:0]  read_byte;
  logic [1:0]  fsm_state;

  flash_access_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .sclk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .flash_addr(flash_addr), .write_byte(write_byte),
    .write_trigger(write_trigger), .read_trigger(read_trigger),
    .write_done(write_done), .read_done(read_done), .read_byte(read_byte),
    .fsm_state(fsm_state)
  );

  // Clock and cycle counter
  initial forever #5 clk = ~clk;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int failures = 0;

  // Scoreboard state
  logic [7:0] ref_mem [logic [23:0]];
  logic [7:0] eng_mem [logic [23:0]];
  logic [7:0] exp_rdata [2];
  logic       exp_q [$];
  logic       ack_q [$];
  log_t       eng_log [$];
  logic       last_served = 1'b1;
  int         wtrig = 0, rtrig = 0, d0 = 0, d1 = 0;
  logic       inflight = 1'b0;
  logic       rst_seen = 1'b0;

  // Engine knobs: latency 0 means random, stray is a non-matching done cycle
  int   eng_lat = 0;
  int   eng_stray = 0;
  logic eng_silent = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_read(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a[7:0] ^ 8'h5A);
  endfunction

  function automatic logic [7:0] eng_read(input logic [23:0] a);
    return eng_mem.exists(a) ? eng_mem[a] : (a[7:0] ^ 8'h5A);
  endfunction

  task automatic drive(input int n, input logic req, input logic we,
                       input logic [23:0] addr, input logic [7:0] wd);
    if (n == 0) begin
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wd;
    end else begin
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wd;
    end
  endtask

  // Monitor: pulse counting, ack order, single-command-in-flight
  initial forever begin
    @(negedge clk);
    if (rst) begin
      rst_seen = 1'b1;
      inflight = 1'b0;
    end
    if (write_trigger || read_trigger) begin
      check("trigger_exclusive", 32'(write_trigger && read_trigger), 0);
      if (write_trigger) wtrig++;
      if (read_trigger)  rtrig++;
    end
    if (r0_ack || r1_ack) begin
      check("dual_ack", 32'(r0_ack && r1_ack), 0);
      check("two_in_flight", 32'(inflight), 0);
      inflight = 1'b1;
      ack_q.push_back(r1_ack);
    end
    if (r0_done) begin d0++; inflight = 1'b0; end
    if (r1_done) begin d1++; inflight = 1'b0; end
  end

  // Behavioural flash engine
  log_t ent_e;
  int   e_lat;
  logic e_abort;
  initial begin
    write_done = 1'b0;
    read_done  = 1'b0;
    read_byte  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && (write_trigger || read_trigger)) begin
        ent_e.we   = write_trigger;
        ent_e.addr = flash_addr;
        ent_e.wb   = write_byte;
        eng_log.push_back(ent_e);
        rst_seen = 1'b0;
        e_lat = (eng_lat != 0) ? eng_lat : int'($urandom_range(2, 12));
        if (!eng_silent) begin
          e_abort = 1'b0;
          for (int k = 1; k <= e_lat && !e_abort; k++) begin
            @(posedge clk); #1;
            write_done = 1'b0;
            read_done  = 1'b0;
            if (rst_seen) e_abort = 1'b1;
            else begin
              check("engine_addr_stable", 32'(flash_addr), 32'(ent_e.addr));
              check("engine_wbyte_stable", 32'(write_byte), 32'(ent_e.wb));
              if (k == e_lat) begin
                if (ent_e.we) begin
                  eng_mem[ent_e.addr] = ent_e.wb;
                  write_done = 1'b1;
                end else begin
                  read_byte = eng_read(ent_e.addr);
                  read_done = 1'b1;
                end
              end else if (k == eng_stray) begin
                if (ent_e.we) read_done = 1'b1;
                else          write_done = 1'b1;
              end
            end
          end
          @(posedge clk); #1;
          write_done = 1'b0;
          read_done  = 1'b0;
        end
      end
    end
  end

  // One requester command: request, ack, completion, scoreboard update
  task automatic run_cmd(input int n, input logic we, input logic [23:0] addr,
                         input logic [7:0] wdata, input int exp_lat,
                         input logic exp_err, input logic solo);
    int         wt0, rt0, od0, t_ack, t_done;
    logic       got, obs_err;
    logic [7:0] obs_rd;
    log_t       ent;
    string      tg;
    wt0 = wtrig; rt0 = rtrig; od0 = (n == 0) ? d1 : d0;
    t_ack = 0; t_done = 0; obs_err = 1'b0; obs_rd = 8'h00;
    tg = $sformatf("r%0d", n);
    @(posedge clk); #1;
    drive(n, 1'b1, we, addr, wdata);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if ((n == 0 && r0_ack) || (n == 1 && r1_ack)) begin
        got = 1'b1;
        t_ack = cyc;
      end
    end
    check({tg, "_ack_seen"}, 32'(got), 1);
    @(posedge clk); #1;
    drive(n, 1'b0, 1'($urandom), 24'($urandom), 8'($urandom));
    if (!got) return;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if ((n == 0 && r0_done) || (n == 1 && r1_done)) begin
        got = 1'b1;
        t_done = cyc;
        obs_err = (n == 0) ? r0_err : r1_err;
        obs_rd  = (n == 0) ? r0_rdata : r1_rdata;
      end
    end
    check({tg, "_done_seen"}, 32'(got), 1);
    if (!got) return;
    if (exp_lat != 0) check({tg, "_latency"}, 32'(t_done - t_ack), 32'(exp_lat));
    if (!exp_err) begin
      if (we) ref_mem[addr] = wdata;
      else    exp_rdata[n] = ref_read(addr);
    end
    check({tg, "_err"}, 32'(obs_err), 32'(exp_err));
    check({tg, "_rdata"}, 32'(obs_rd), 32'(exp_rdata[n]));
    if (eng_log.size() == 0) begin
      check({tg, "_engine_saw_cmd"}, 0, 1);
    end else begin
      ent = eng_log.pop_front();
      check({tg, "_engine_op"}, 32'(ent.we), 32'(we));
      check({tg, "_engine_addr"}, 32'(ent.addr), 32'(addr));
      if (we) check({tg, "_engine_wbyte"}, 32'(ent.wb), 32'(wdata));
    end
    if (solo) begin
      check({tg, "_write_trig_count"}, 32'(wtrig - wt0), we ? 32'd1 : 32'd0);
      check({tg, "_read_trig_count"}, 32'(rtrig - rt0), we ? 32'd0 : 32'd1);
      check({tg, "_other_no_done"}, 32'((n == 0) ? d1 : d0), 32'(od0));
    end
    last_served = n[0];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit");
  end

  logic       got_m;
  logic       first;
  int         n_r, lat_r, d0_s, d1_s;
  logic       we_r;
  logic [23:0] addr_r;

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 24'h0, 8'h0);
    drive(1, 1'b0, 1'b0, 24'h0, 8'h0);
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(fsm_state), 32'(ST_IDLE));
    check("reset_pulses", 32'({r0_ack, r1_ack, r0_done, r1_done, r0_err, r1_err,
                                write_trigger, read_trigger}), 0);
    check("reset_r0_rdata", 32'(r0_rdata), 0);
    check("reset_r1_rdata", 32'(r1_rdata), 0);
    check("reset_flash_addr", 32'(flash_addr), 0);
    check("reset_write_byte", 32'(write_byte), 0);

    // r0 write 0x33 to 0x000000, engine done after 10 cycles
    eng_lat = 10;
    run_cmd(0, 1'b1, 24'h000000, 8'h33, 12, 1'b0, 1'b1);
    check("engine_mem_0", 32'(eng_read(24'h000000)), 32'h33);

    // r1 read 0x7FF000, engine returns 0x26
    eng_mem[24'h7FF000] = 8'h26;
    ref_mem[24'h7FF000] = 8'h26;
    eng_lat = int'($urandom_range(3, 20));
    run_cmd(1, 1'b0, 24'h7FF000, 8'h00, eng_lat + 2, 1'b0, 1'b1);
    check("r1_rdata_0x26", 32'(r1_rdata), 32'h26);

    // Randomized solo commands over a small address window
    for (int i = 0; i < 8; i++) begin
      n_r    = int'($urandom_range(0, 1));
      we_r   = 1'($urandom_range(0, 1));
      lat_r  = int'($urandom_range(1, 15));
      addr_r = {20'h00010, 4'($urandom_range(0, 7))};
      eng_lat = lat_r;
      run_cmd(n_r, we_r, addr_r, 8'($urandom), lat_r + 2, 1'b0, 1'b1);
    end
    eng_lat = 5;
    run_cmd(0, 1'b0, 24'h000000, 8'h00, 7, 1'b0, 1'b1);

    // Silent engine: timeout 64 cycles after WAIT entry, rdata kept
    eng_silent = 1'b1;
    run_cmd(0, 1'b0, 24'h0000AA, 8'h00, TO + 2, 1'b1, 1'b1);
    eng_silent = 1'b0;

    // Read with a stray write_done 5 cycles before read_done
    eng_lat = 8;
    eng_stray = 3;
    run_cmd(0, 1'b0, 24'h00ABCD, 8'h00, 10, 1'b0, 1'b1);
    eng_stray = 0;

    // Simultaneous requests: acks must alternate starting with the other side
    eng_lat = 0;
    ack_q.delete();
    exp_q.delete();
    first = ~last_served;
    for (int i = 0; i < 6; i++) exp_q.push_back(first ^ i[0]);
    fork
      for (int k = 0; k < 3; k++)
        run_cmd(0, 1'($urandom_range(0, 1)), {20'h00020, 4'($urandom_range(0, 3))},
                8'($urandom), 0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++)
        run_cmd(1, 1'($urandom_range(0, 1)), {20'h00020, 4'($urandom_range(0, 3))},
                8'($urandom), 0, 1'b0, 1'b0);
    join
    check("ack_order_len", 32'(ack_q.size()), 6);
    for (int i = 0; i < 6 && ack_q.size() > 0; i++)
      check($sformatf("ack_order_%0d", i), 32'(ack_q.pop_front()), 32'(exp_q.pop_front()));

    // Reset two cycles into WAIT
    eng_lat = 20;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 24'h123456, 8'h00);
    got_m = 1'b0;
    for (int i = 0; i < 50 && !got_m; i++) begin
      @(negedge clk);
      if (r0_ack) got_m = 1'b1;
    end
    check("rst_case_ack", 32'(got_m), 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 24'h0, 8'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_cycle_no_pulses", 32'({r0_done, r1_done, r0_ack, r1_ack,
                                       write_trigger, read_trigger}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_state_idle", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_flash_addr", 32'(flash_addr), 0);
    check("rst_write_byte", 32'(write_byte), 0);
    check("rst_r0_rdata", 32'(r0_rdata), 0);
    check("rst_r1_rdata", 32'(r1_rdata), 0);
    check("rst_pulses", 32'({r0_done, r1_done, r0_err, r1_err, write_trigger, read_trigger}), 0);
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    last_served  = 1'b1;
    d0_s = d0;
    d1_s = d1;
    repeat (30) @(negedge clk);
    @(posedge clk);
    check("rst_no_done_r0", 32'(d0), 32'(d0_s));
    check("rst_no_done_r1", 32'(d1), 32'(d1_s));
    eng_log.delete();

    // Normal service after reset
    eng_lat = 6;
    run_cmd(1, 1'b0, 24'h7FF000, 8'h00, 8, 1'b0, 1'b1);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flash_access_arbiter.md
# flash_access_arbiter

Shares the single `spi_w25q128` byte-read/byte-write engine between two independent requesters, e.g. the key-driven UI path and a background logger. It does round-robin arbitration, latches each winning command, sequences the engine's trigger/done handshake, and returns read data with completion status. A watchdog reports a stalled engine as an error instead of letting it hang the bus. It sits between the requesters and the `spi_w25q128` instance in the top level.

## Interface
- `TIMEOUT_CYC`, 25_000_000: max `sclk` cycles in WAIT before abort (500 ms at 50 MHz; covers erase + program).
- `sclk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `rN_req` in 1 (N=0,1): request level; hold until `rN_ack`.
- `rN_we` in 1: 1 = write byte, 0 = read byte.
- `rN_addr` in 24: flash byte address.
- `rN_wdata` in 8: write data (ignored for reads).
- `rN_ack` out 1: one-cycle pulse; command latched, requester may change inputs.
- `rN_done` out 1: one-cycle completion pulse.
- `rN_rdata` out 8: read result, valid with `rN_done`; held until that requester's next done.
- `rN_err` out 1: valid with `rN_done`; 1 = timeout.
- `flash_addr` out 24, `write_byte` out 8: to engine; stable from ISSUE through end of WAIT.
- `write_trigger`, `read_trigger` out 1: one-cycle pulses to engine.
- `write_done`, `read_done` in 1: engine completion pulses.
- `read_byte` in 8: engine read result, sampled on `read_done`.

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE
  - If any `rN_req`=1, pick the winner and go to ISSUE.
  - Winner: the sole requester, else the one not served last (`last_gnt`, reset 1, so r0 wins the first tie).
  - Latch `we`, `addr`, `wdata`, and the grant id.
  - Pulse the winner's `rN_ack` in this same cycle.
- ISSUE
  - Pulse exactly one trigger: `write_trigger` if latched we=1, else `read_trigger`.
  - Clear the timeout counter. Go to WAIT.
- WAIT
  - Count cycles.
  - On the matching done (`write_done` for a write, `read_done` for a read), go to RESP with err=0. For a read, capture `read_byte` in the same cycle.
  - The non-matching done pulse is ignored.
  - When the counter reaches `TIMEOUT_CYC`-1 with no matching done, go to RESP with err=1. `rN_rdata` keeps its old value.
- RESP
  - Pulse the winner's `rN_done`, with `rN_err`/`rN_rdata` valid.
  - Set `last_gnt` to the winner. Go to IDLE.
- A requester that keeps `req` high after ack is treated as a new request in the next IDLE.
- Counter width: $clog2(TIMEOUT_CYC+1). The counter saturates and never wraps.

## Timing
- Reset values:
  - state IDLE, `last_gnt`=1.
  - All `ack`/`done`/`err`/trigger outputs 0.
  - `rN_rdata`=0, `flash_addr`=0, `write_byte`=0.
- Grant latency: `req` seen at edge T gives ack at T; trigger at T+1; WAIT from T+2.
- Done handling:
  - Done pulses are sampled only in WAIT. A done arriving during ISSUE is ignored.
  - Matching done at cycle D gives `rN_done` at D+1.
- Minimum command cost is 4 cycles (IDLE, ISSUE, WAIT, RESP). Back-to-back requests from both sides alternate r0, r1, r0, …
- `rst` mid-operation: return to IDLE on the next edge and drop all pulses. No done is issued for the aborted command. The engine shares `rst`, so it aborts too.
- A timed-out engine is not reset by this block. A late done arriving after RESP is ignored, because only WAIT samples done.

## Structure
- Shared package (`flash_pkg`): state encoding; `FLASH_ADDR_W`=24, `FLASH_DATA_W`=8; op encoding (OP_READ=0, OP_WRITE=1).
- One natural sub-module, `rr_arb2`: combinational 2-way round-robin pick from `req[1:0]` and `last_gnt`. Everything else lives in the single FSM module.

## Test plan
Use a behavioural engine model with programmable latency, TIMEOUT_CYC=64.
- r0 write addr 0x000000, data 0x33, engine done after 10 cycles:
  - `write_trigger` exactly one pulse, with `flash_addr`=0x000000 and `write_byte`=0x33 stable until done.
  - `r0_done`=1, `r0_err`=0.
- r1 read addr 0x7FF000, engine returns 0x26: `read_trigger` one pulse; `r1_done` with `r1_rdata`=0x26, `r1_err`=0.
- r0 and r1 assert `req` in the same cycle, three times each: ack order r0, r1, r0, r1, r0, r1; never two commands in flight.
- Read with the engine silent: `r0_done`=1 and `r0_err`=1 exactly 64 cycles after WAIT entry; `r0_rdata` unchanged.
- Read in flight, engine pulses `write_done` first, then `read_done` 5 cycles later: the `write_done` is ignored; completion follows the `read_done`.
- `rst` asserted two cycles into WAIT: the next cycle is IDLE, no `rN_done`, outputs at reset values; a new r1 request is then served normally.
